// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL,
        RUN
    } state_t;

    localparam int         IMEM_DEPTH = 16;
    localparam int         IMEM_AW    = 4;
    localparam logic [7:0] NOP_INSTR  = 8'h40;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, asynchronous read, no reset.
module imem_array #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a program byte stream into instruction memory, NOP-pads the tail,
// holds the core in reset while loading and serves mem[pc] once running.
module imem_loader
    import imem_pkg::*;
#(
    parameter int         DEPTH = IMEM_DEPTH,
    parameter logic [7:0] NOP   = NOP_INSTR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_start,
    input  logic [4:0] load_count,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [7:0] pc,
    output logic [7:0] instruction,
    output logic       cpu_reset,
    output logic       load_done,
    output logic       busy
);

    localparam int                 CW   = IMEM_AW + 1;
    localparam logic [CW-1:0]      FULL = CW'(DEPTH);
    localparam logic [IMEM_AW-1:0] LAST = IMEM_AW'(DEPTH - 1);

    state_t             state;
    logic [IMEM_AW-1:0] waddr;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      count_clamped;
    logic               we;
    logic [7:0]         wdata;
    logic [7:0]         rdata;

    assign count_clamped = (load_count > FULL) ? FULL : load_count;

    assign we    = ((state == LOAD) && in_valid) || (state == FILL);
    assign wdata = (state == FILL) ? NOP : in_data;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (IMEM_AW),
        .WIDTH (8)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (pc[IMEM_AW-1:0]),
        .rdata (rdata)
    );

    // Only addresses inside the array and only while running reach the core.
    assign instruction = ((state == RUN) && (pc[7:IMEM_AW] == '0)) ? rdata : NOP;

    // Outputs are set alongside the state transition so they track state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            waddr     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            load_done <= 1'b0;
            unique case (state)
                IDLE, RUN: begin
                    if (load_start && (load_count != '0)) begin
                        state     <= LOAD;
                        cnt       <= count_clamped;
                        waddr     <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        cpu_reset <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        waddr <= waddr + 1'b1;
                        if ({1'b0, waddr} == cnt - 1'b1) begin
                            in_ready <= 1'b0;
                            if (cnt < FULL) begin
                                state <= FILL;
                            end else begin
                                state     <= RUN;
                                busy      <= 1'b0;
                                cpu_reset <= 1'b0;
                                load_done <= 1'b1;
                            end
                        end
                    end
                end
                FILL: begin
                    waddr <= waddr + 1'b1;
                    if (waddr == LAST) begin
                        state     <= RUN;
                        busy      <= 1'b0;
                        cpu_reset <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load latency, stalls, clamping, reset abort, reload.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic [4:0] load_count;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] pc;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic       load_done;
    logic       busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] prog [16];
    logic [7:0] img  [16];

    imem_loader #(
        .DEPTH (16),
        .NOP   (8'h40)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_count  (load_count),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .pc          (pc),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .load_done   (load_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Set pc, let one cycle pass in RUN, then compare the fetched word.
    task automatic check_pc(input string tag, input logic [7:0] p, input logic [7:0] exp);
        pc = p;
        tick();
        check(tag, 32'(instruction), 32'(exp));
    endtask

    task automatic check_image(input string tag);
        for (int a = 0; a < 16; a++) begin
            check_pc(tag, 8'(a), img[a]);
        end
    endtask

    // Start a load of prog[0..nb-1]; stall_len invalid cycles are inserted
    // before byte stall_at with garbage on in_data.
    task automatic do_load(input string tag, input int cnt, input int nb,
                           input int stall_at, input int stall_len, input int exp_lat);
        int s;
        s          = cyc;
        load_start = 1'b1;
        load_count = cnt[4:0];
        tick();
        load_start = 1'b0;
        load_count = '0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_instr_nop"}, 32'(instruction), 32'h40);
        for (int i = 0; i < nb; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    in_valid = 1'b0;
                    in_data  = 8'hFF;
                    tick();
                end
            end
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = prog[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'hFF;
        for (int k = 0; k < 64 && !load_done; k++) begin
            tick();
        end
        check({tag, "_latency"}, 32'(cyc - s), 32'(exp_lat));
        check({tag, "_run_cpu_reset"}, 32'(cpu_reset), 32'd0);
        check({tag, "_run_busy"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(load_done), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        pc         = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        for (int p = 0; p < 4; p++) begin
            check_pc("rst_instr", 8'(p), 8'h40);
        end
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);

        // Continuous 10-byte load.
        prog[0] = 8'h43; prog[1] = 8'h43; prog[2] = 8'h43; prog[3] = 8'h41;
        prog[4] = 8'h54; prog[5] = 8'h68; prog[6] = 8'h8F; prog[7] = 8'h29;
        prog[8] = 8'h55; prog[9] = 8'hC7;
        for (int a = 0; a < 16; a++) img[a] = (a < 10) ? prog[a] : 8'h40;
        do_load("load10", 10, 10, -1, 0, 17);
        check_pc("load10_pc6", 8'd6, 8'h8F);
        check_pc("load10_pc9", 8'd9, 8'hC7);
        for (int p = 10; p < 16; p++) begin
            check_pc("load10_pad", 8'(p), 8'h40);
        end
        check_pc("load10_pc200", 8'd200, 8'h40);

        // Same load with 3 stall cycles after byte 4: garbage must not land.
        do_load("stall", 10, 10, 4, 3, 20);
        check_image("stall_img");

        // Count 0 from IDLE is ignored.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_start = 1'b1;
        load_count = 5'd0;
        tick();
        load_start = 1'b0;
        check("zero_in_ready", 32'(in_ready), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        tick();
        check("zero_in_ready2", 32'(in_ready), 32'd0);
        check("zero_cpu_reset", 32'(cpu_reset), 32'd1);

        // Count 20 clamps to 16: no FILL, RUN at T+17.
        for (int a = 0; a < 16; a++) begin
            prog[a] = 8'(8'h10 + 8'(a * 5));
            img[a]  = prog[a];
        end
        do_load("clamp", 20, 16, -1, 0, 17);
        check_image("clamp_img");

        // Reset after 5 bytes of a 10-byte load.
        for (int a = 0; a < 10; a++) prog[a] = 8'(8'hA0 + 8'(a));
        load_start = 1'b1;
        load_count = 5'd10;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = prog[i];
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tick();
        check("abort_idle_ready", 32'(in_ready), 32'd0);

        // Fresh 2-byte load after the abort.
        prog[0] = 8'hA5;
        prog[1] = 8'h5A;
        for (int a = 0; a < 16; a++) img[a] = (a < 2) ? prog[a] : 8'h40;
        do_load("load2", 2, 2, -1, 0, 17);
        check_image("load2_img");

        // Reload from RUN with a single byte.
        pc      = 8'd0;
        prog[0] = 8'h3C;
        for (int a = 0; a < 16; a++) img[a] = (a < 1) ? prog[a] : 8'h40;
        do_load("reload1", 1, 1, -1, 0, 17);
        check_image("reload1_img");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
